// File: rtl/uart_rx_param.sv
`timescale 1ns / 1ps
// uart_rx_param
//   Parametrised asynchronous serial receiver. The line is synchronised,
//   a falling edge starts a frame, and every bit is sampled mid-bit using
//   a baud down-counter. Data arrives LSB first, optionally followed by a
//   parity bit, then one or two stop bits. A completed frame is always
//   delivered on cmd with rdy=1, together with that frame's error flags.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   RX         serial line, idle high, asynchronous to clk
//   clr_rdy    synchronous clear of rdy and all error flags
//   rdy        a received word is valid on cmd
//   cmd        last received data word
//   frame_err  a stop-bit sample of the last frame was 0
//   parity_err parity mismatch on the last frame (0 when PARITY_EN=0)
//   overrun    a frame completed while rdy was still 1
module uart_rx_param #(
  parameter int BAUD_DIV   = 2604,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 clr_rdy,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] cmd,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_BITS + 2);

  localparam logic [CW-1:0] HALF      = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] FULL      = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]        baud_cnt, cnt_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 par_bit, par_nxt;
  logic                 stop_bad, bad_nxt;
  logic                 done, par_bad;
  logic                 fall, tick;

  assign fall = rx_prev & ~rx_sync;
  assign tick = (baud_cnt == '0);

  // NOTE: the synchroniser and edge-detect flops reset to 1 (the idle line
  // level) so that leaving reset never looks like a start edge.
  // NOTE: all state updates use non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      stop_bad <= 1'b0;
    end else begin
      rx_meta  <= RX;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      state    <= state_nxt;
      baud_cnt <= cnt_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      par_bit  <= par_nxt;
      stop_bad <= bad_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    par_nxt   = par_bit;
    bad_nxt   = stop_bad;
    done      = 1'b0;

    if (state != IDLE && !tick) cnt_nxt = baud_cnt - CW'(1);

    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = START;
          cnt_nxt   = HALF;
          bit_nxt   = '0;
          bad_nxt   = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          // A line back high at mid start bit was a glitch: drop silently.
          if (rx_sync) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            cnt_nxt   = FULL;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_nxt = {rx_sync, shift[DATA_BITS-1:1]};
          cnt_nxt   = FULL;
          if (bit_cnt == LAST_DATA) begin
            bit_nxt   = '0;
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_nxt = bit_cnt + BW'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          par_nxt   = rx_sync;
          cnt_nxt   = FULL;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (!rx_sync) bad_nxt = 1'b1;
          if (bit_cnt == LAST_STOP) begin
            // Back to IDLE at mid stop bit so a frame that follows with
            // no idle gap still has its start edge seen.
            done      = 1'b1;
            state_nxt = IDLE;
            bit_nxt   = '0;
            cnt_nxt   = '0;
          end else begin
            bit_nxt = bit_cnt + BW'(1);
            cnt_nxt = FULL;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign par_bad = (PARITY_EN != 0) && ((^shift ^ par_bit) != 1'(PARITY_ODD));

  // Completion has priority over clr_rdy in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy        <= 1'b0;
      cmd        <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (done) begin
      rdy        <= 1'b1;
      cmd        <= shift;
      frame_err  <= bad_nxt;
      parity_err <= par_bad;
      overrun    <= ~clr_rdy & (overrun | rdy);
    end else if (clr_rdy) begin
      rdy        <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised successor to the fixed 8N1 line-follower UART receiver.
- Deserialises an asynchronous serial line into a DATA_BITS-wide command word.
- Configurable baud divisor, optional parity (even or odd), and 1 or 2 stop bits.
- Adds framing-error, parity-error and overrun flags, and false-start rejection. Feeds the command processor through the existing rdy/clr_rdy handshake.

Parameters:
- BAUD_DIV, 2604: clk cycles per bit (50 MHz / 19200 baud); legal range 16..65535.
- DATA_BITS, 8: data bits per frame, sent LSB first; legal range 5..9.
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: with PARITY_EN=1, 0 = even parity, 1 = odd parity.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- RX  input  1  serial line; idle high; asynchronous to clk.
- clr_rdy  input  1  synchronous clear of rdy and all error flags.
- rdy  output  1  a received word is valid on cmd.
- cmd  output  DATA_BITS  last received data word.
- frame_err  output  1  a stop-bit sample of the last frame was 0.
- parity_err  output  1  parity mismatch on the last frame; always 0 when PARITY_EN=0.
- overrun  output  1  a frame completed while rdy was still 1.

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of the state mid-frame:
  - rdy=0, cmd=0, frame_err=0, parity_err=0, overrun=0;
  - FSM=IDLE, counters=0;
  - both synchroniser flops preset to 1.
- RX passes through a 2-flop synchroniser. Falling-edge detection is performed on the synchronised signal.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a synchronised falling edge; baud counter loaded with BAUD_DIV/2 (integer division).
  - START: at counter expiry (mid start bit), sample RX.
    - Sample 1: false start; return to IDLE; no flag or output change.
    - Sample 0: go to DATA; counter reloaded with BAUD_DIV-1.
  - DATA: sample every BAUD_DIV cycles into a shift register, LSB first. After DATA_BITS samples go to PARITY if PARITY_EN, else to STOP.
  - PARITY: one sample. Mismatch when XOR(data, sampled parity bit) != PARITY_ODD.
  - STOP: STOP_BITS samples, BAUD_DIV apart. Any 0 sample marks a framing error for this frame.
- Frame completion (cycle after the final stop sample, taken mid-bit):
  - cmd <= shifted data; rdy <= 1;
  - frame_err and parity_err <= this frame's results;
  - FSM returns to IDLE immediately, so the next start edge is accepted half a bit early. Back-to-back frames with no idle gap must be received.
- A frame with a framing or parity error is still delivered: cmd is loaded and rdy=1, with the error flag set.
- Overrun: if rdy=1 and clr_rdy=0 at completion, then overrun <= 1 and cmd is overwritten with the new word. overrun stays set until clr_rdy or reset.
- clr_rdy=1: next cycle rdy, frame_err, parity_err and overrun are all 0. cmd holds its value.
  - clr_rdy held high does not block reception.
  - clr_rdy in the same cycle as completion: completion wins. rdy=1, new error flags, overrun=0.
- Latency: rdy rises L cycles after RX first goes low at the pin.
  - L = BAUD_DIV/2 + (DATA_BITS + PARITY_EN + STOP_BITS) * BAUD_DIV + 3, tolerance ±2 cycles.
  - With defaults (8N1, BAUD_DIV=2604): L = 1302 + 9*2604 + 3 = 24741.
- Glitch rejection: RX low pulses shorter than BAUD_DIV/2 - 2 cycles in IDLE must not produce a frame.
- Counter width: $clog2(BAUD_DIV). Bit counter width: $clog2(DATA_BITS+2).

Test Plan:
- Defaults, existing uart_trans driving RX, all 256 data values, clr_rdy pulsed after each word:
  - rdy=1 within 24741±2 cycles of the start edge; cmd == tx_data; all error flags 0;
  - rdy=0 one cycle after clr_rdy.
- PARITY_EN=1, PARITY_ODD=0, BAUD_DIV=16, bench driving frame 0xA5 with parity bit 0:
  - cmd=0xA5, parity_err=0.
  - Same frame with parity bit 1: cmd=0xA5, rdy=1, parity_err=1.
- Defaults, stop bit driven 0 for frame 0x3C: cmd=0x3C, rdy=1, frame_err=1. A following clean 0x11 (after clr_rdy) gives frame_err=0.
- BAUD_DIV=16, 0x55 then 0xAA back-to-back with no idle and clr_rdy never asserted:
  - after the first frame: rdy=1, overrun=0, cmd=0x55;
  - after the second frame: cmd=0xAA, overrun=1;
  - clr_rdy then clears rdy and overrun.
- BAUD_DIV=16, RX low pulse of 5 cycles in IDLE: no rdy within 200 cycles. A valid 0x81 sent afterwards is received correctly.
- Defaults, rst_n pulsed low mid DATA of frame 0xF0:
  - all outputs 0 immediately (asynchronously);
  - the remainder of the aborted frame produces no rdy;
  - the next full frame 0x0F gives cmd=0x0F.
